// File: rtl/aes_key_sched_ctrl_if.sv
// Key-load handshake and round-key read port of the AES-128 key-schedule controller.
// The master is the key source / cipher core; the slave is the controller.
interface aes_key_sched_ctrl_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_data;
    logic         rd_ok;

    modport master (
        output key_in, key_valid, rd_en, rd_round,
        input  key_ready, busy, keys_valid, rd_data, rd_ok
    );

    modport slave (
        input  key_in, key_valid, rd_en, rd_round,
        output key_ready, busy, keys_valid, rd_data, rd_ok
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry register file,
// with a shared SubWord datapath and a latency-1 registered read port.
module aes_key_sched_ctrl #(
    parameter int NRK          = 11,
    parameter bit ZERO_ON_MISS = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    aes_key_sched_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] LAST_RK = 4'(NRK - 1);
    localparam logic [3:0] NUM_RK  = 4'(NRK);

    state_t       state_r, next_state_s;
    logic [3:0]   wr_cnt_r, wr_cnt_next_s;
    logic [7:0]   rcon_r, rcon_next_s;
    logic [127:0] prev_r, prev_next_s;
    logic [127:0] rk_r [NRK];
    logic         rk_we_s;
    logic [3:0]   rk_waddr_s;
    logic [127:0] rk_wdata_s;
    logic         accept_s;
    logic         key_ready_r, busy_r, keys_valid_r;
    logic [127:0] rd_data_r;
    logic         rd_ok_r;
    logic [31:0]  rot_s, sub_s, t_s, n0_s, n1_s, n2_s, n3_s;
    logic [127:0] step_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            else      p = p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254 by square-and-multiply) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = x;
        for (int i = 0; i < 6; i++) inv = gf_mul(gf_mul(inv, inv), x);
        inv = gf_mul(inv, inv);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign rot_s  = {prev_r[23:0], prev_r[31:24]};
    assign sub_s  = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])};
    assign t_s    = sub_s ^ {rcon_r, 24'h000000};
    assign n0_s   = prev_r[127:96] ^ t_s;
    assign n1_s   = prev_r[95:64]  ^ n0_s;
    assign n2_s   = prev_r[63:32]  ^ n1_s;
    assign n3_s   = prev_r[31:0]   ^ n2_s;
    assign step_s = {n0_s, n1_s, n2_s, n3_s};

    // Next-state, expansion-step and register-file write control.
    always_comb begin
        next_state_s  = state_r;
        wr_cnt_next_s = wr_cnt_r;
        rcon_next_s   = rcon_r;
        prev_next_s   = prev_r;
        rk_we_s       = 1'b0;
        rk_waddr_s    = wr_cnt_r;
        rk_wdata_s    = step_s;
        accept_s      = bus.key_valid && key_ready_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    next_state_s  = EXPAND;
                    wr_cnt_next_s = 4'd1;
                    rcon_next_s   = 8'h01;
                    prev_next_s   = bus.key_in;
                    rk_we_s       = 1'b1;
                    rk_waddr_s    = 4'd0;
                    rk_wdata_s    = bus.key_in;
                end else begin
                    next_state_s  = state_r;
                end
            end
            EXPAND: begin
                rk_we_s       = 1'b1;
                rk_waddr_s    = wr_cnt_r;
                rk_wdata_s    = step_s;
                prev_next_s   = step_s;
                wr_cnt_next_s = wr_cnt_r + 4'd1;
                rcon_next_s   = xtime(rcon_r);
                if (wr_cnt_r == LAST_RK) next_state_s = DONE;
                else                     next_state_s = EXPAND;
            end
            default: begin
                next_state_s  = IDLE;
                wr_cnt_next_s = 4'd0;
            end
        endcase
    end

    // Control state plus status outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            wr_cnt_r     <= 4'd0;
            rcon_r       <= 8'h01;
            prev_r       <= 128'd0;
            key_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            keys_valid_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            wr_cnt_r     <= wr_cnt_next_s;
            rcon_r       <= rcon_next_s;
            prev_r       <= prev_next_s;
            key_ready_r  <= (next_state_s != EXPAND);
            busy_r       <= (next_state_s == EXPAND);
            keys_valid_r <= (next_state_s == DONE);
        end
    end

    // Round-key storage; contents are meaningful only below wr_cnt, so no reset.
    always_ff @(posedge clk) begin
        if (rk_we_s && rst_n) rk_r[rk_waddr_s] <= rk_wdata_s;
    end

    // Latency-1 read port; the round being written this edge is still a miss.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r <= 128'd0;
            rd_ok_r   <= 1'b0;
        end else if (bus.rd_en) begin
            rd_ok_r <= (bus.rd_round < wr_cnt_r);
            if (bus.rd_round < wr_cnt_r)
                rd_data_r <= rk_r[bus.rd_round];
            else if (!ZERO_ON_MISS && (bus.rd_round < NUM_RK))
                rd_data_r <= rk_r[bus.rd_round];
            else
                rd_data_r <= 128'd0;
        end else begin
            rd_data_r <= rd_data_r;
            rd_ok_r   <= rd_ok_r;
        end
    end

    assign bus.key_ready  = key_ready_r;
    assign bus.busy       = busy_r;
    assign bus.keys_valid = keys_valid_r;
    assign bus.rd_data    = rd_data_r;
    assign bus.rd_ok      = rd_ok_r;
endmodule
